// File: rtl/momentum_pkg.sv
// momentumGO board: cell codes, op codes, FSM states and ownership helper.
package momentum_pkg;

    localparam logic [2:0] C_EMPTY        = 3'd0;
    localparam logic [2:0] C_RED_CLAIMED  = 3'd1;
    localparam logic [2:0] C_BLUE_CLAIMED = 3'd2;
    localparam logic [2:0] C_RED_PLAYER   = 3'd3;
    localparam logic [2:0] C_BLUE_PLAYER  = 3'd4;
    localparam logic [2:0] C_RED_BOMB     = 3'd5;
    localparam logic [2:0] C_BLUE_BOMB    = 3'd6;
    localparam logic [2:0] C_RESERVED     = 3'd7;

    localparam logic [1:0] OP_WRITE     = 2'd0;
    localparam logic [1:0] OP_CLAIM     = 2'd1;
    localparam logic [1:0] OP_ERASE     = 2'd2;
    localparam logic [1:0] OP_CLEAR_ALL = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_RED,
        OWN_BLUE
    } owner_t;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_EXEC
    } state_t;

    function automatic owner_t owner(input logic [2:0] c);
        case (c)
            C_RED_CLAIMED, C_RED_PLAYER, C_RED_BOMB:    owner = OWN_RED;
            C_BLUE_CLAIMED, C_BLUE_PLAYER, C_BLUE_BOMB: owner = OWN_BLUE;
            default:                                    owner = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/board_ram.sv
// Board cell array: one write port, two registered read ports.
// Reads return the value held before a same-cycle write.
module board_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [2:0]    wdata,
    input  logic [AW-1:0] cmd_addr,
    output logic [2:0]    cmd_rdata,
    input  logic [AW-1:0] disp_addr,
    output logic [2:0]    disp_rdata
);

    logic [2:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        cmd_rdata  <= mem[cmd_addr];
        disp_rdata <= mem[disp_addr];
    end

endmodule

// File: rtl/momentum_board.sv
// momentumGO board store: command FSM, claim rules, clear sweep
// and live per-player ownership counts.
module momentum_board
    import momentum_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int X_W    = $clog2(WIDTH),
    parameter int Y_W    = $clog2(HEIGHT),
    parameter int CNT_W  = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [X_W-1:0]   cmd_x,
    input  logic [Y_W-1:0]   cmd_y,
    input  logic [2:0]       cmd_data,
    output logic             resp_valid,
    output logic             resp_ok,
    output logic [2:0]       resp_old,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    output logic [2:0]       rd_data,
    output logic             busy,
    output logic [CNT_W-1:0] red_count,
    output logic [CNT_W-1:0] blue_count
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int AW    = $clog2(CELLS);

    function automatic logic [AW-1:0] lin(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        int a;
        a = int'(y) * WIDTH + int'(x);
        return AW'(a);
    endfunction

    state_t        state, state_nx;
    logic [AW-1:0] idx;
    logic          clr_rsp;
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [2:0]    data_q;
    logic          inr_q;
    logic          rd_zero_q;

    logic          accept, sweep_last;
    logic          cmd_inr, rd_inr;
    logic [AW-1:0] cmd_addr, disp_addr;
    logic [2:0]    ram_cmd, ram_disp;
    logic [2:0]    old_code, new_code;
    logic          wr_ok, exec_we;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [2:0]    ram_wdata;
    logic          red_inc, red_dec, blue_inc, blue_dec;

    assign accept     = (state == S_IDLE) && cmd_valid;
    assign sweep_last = (idx == AW'(CELLS - 1));
    assign cmd_inr    = (int'(cmd_x) < WIDTH) && (int'(cmd_y) < HEIGHT);
    assign rd_inr     = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
    assign cmd_addr   = cmd_inr ? lin(cmd_x, cmd_y) : '0;
    assign disp_addr  = rd_inr ? lin(rd_x, rd_y) : '0;

    // Rule check for the latched command; old reads as EMPTY when out of range.
    always_comb begin
        old_code = inr_q ? ram_cmd : C_EMPTY;
        new_code = C_EMPTY;
        wr_ok    = 1'b0;
        case (op_q)
            OP_WRITE: begin
                new_code = data_q;
                wr_ok    = inr_q;
            end
            OP_ERASE: begin
                new_code = C_EMPTY;
                wr_ok    = inr_q;
            end
            OP_CLAIM: begin
                new_code = data_q[0] ? C_BLUE_CLAIMED : C_RED_CLAIMED;
                wr_ok    = inr_q && (old_code <= C_BLUE_CLAIMED);
            end
            default: begin
                new_code = C_EMPTY;
                wr_ok    = 1'b0;
            end
        endcase
        exec_we  = (state == S_EXEC) && wr_ok;
        red_inc  = owner(new_code) == OWN_RED;
        red_dec  = owner(old_code) == OWN_RED;
        blue_inc = owner(new_code) == OWN_BLUE;
        blue_dec = owner(old_code) == OWN_BLUE;
    end

    always_comb begin
        ram_we    = exec_we;
        ram_waddr = addr_q;
        ram_wdata = new_code;
        if (state == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = idx;
            ram_wdata = C_EMPTY;
        end
    end

    board_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_ram (
        .clk        (clk),
        .we         (ram_we),
        .waddr      (ram_waddr),
        .wdata      (ram_wdata),
        .cmd_addr   (cmd_addr),
        .cmd_rdata  (ram_cmd),
        .disp_addr  (disp_addr),
        .disp_rdata (ram_disp)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_CLEAR;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            state == S_CLEAR: if (sweep_last) state_nx = S_IDLE;
            state == S_IDLE:
                if (cmd_valid)
                    state_nx = (cmd_op == OP_CLEAR_ALL) ? S_CLEAR : S_EXEC;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state == S_CLEAR);
    end

    assign rd_data = (busy || rd_zero_q) ? 3'd0 : ram_disp;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            clr_rsp    <= 1'b0;
            op_q       <= OP_WRITE;
            addr_q     <= '0;
            data_q     <= '0;
            inr_q      <= 1'b0;
            rd_zero_q  <= 1'b1;
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            resp_old   <= '0;
            red_count  <= '0;
            blue_count <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            resp_old   <= '0;
            rd_zero_q  <= !rd_inr;
            if (state == S_CLEAR) begin
                idx <= idx + 1'b1;
                if (sweep_last) begin
                    idx        <= '0;
                    clr_rsp    <= 1'b0;
                    resp_valid <= clr_rsp;
                    resp_ok    <= clr_rsp;
                end
            end
            if (accept) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                inr_q  <= cmd_inr;
                if (cmd_op == OP_CLEAR_ALL) begin
                    clr_rsp    <= 1'b1;
                    idx        <= '0;
                    red_count  <= '0;
                    blue_count <= '0;
                end
            end
            if (state == S_EXEC) begin
                resp_valid <= 1'b1;
                resp_ok    <= wr_ok;
                resp_old   <= old_code;
                if (wr_ok) begin
                    red_count  <= red_count + CNT_W'(red_inc)
                                  - CNT_W'(red_dec);
                    blue_count <= blue_count + CNT_W'(blue_inc)
                                  - CNT_W'(blue_dec);
                end
            end
        end
    end

endmodule

// File: tb/tb_momentum_board.sv
// Directed bench for momentum_board: 16x16 board with a reference grid
// and response scoreboard, plus a 12x12 board for range rejection.
module tb_momentum_board;

    localparam int W = 16;
    localparam int H = 16;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_x = '0, cmd_y = '0;
    logic [2:0] cmd_data = '0;
    logic       resp_valid, resp_ok;
    logic [2:0] resp_old;
    logic [3:0] rd_x = '0, rd_y = '0;
    logic [2:0] rd_data;
    logic       busy;
    logic [8:0] red_count, blue_count;

    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [1:0] b_op = '0;
    logic [3:0] b_x = '0, b_y = '0;
    logic [2:0] b_data = '0;
    logic       b_resp_valid, b_resp_ok;
    logic [2:0] b_resp_old;
    logic [3:0] b_rd_x = '0, b_rd_y = '0;
    logic [2:0] b_rd_data;
    logic       b_busy;
    logic [7:0] b_red, b_blue;

    momentum_board dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_ok(resp_ok),
        .resp_old(resp_old),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .busy(busy),
        .red_count(red_count), .blue_count(blue_count)
    );

    momentum_board #(.WIDTH(12), .HEIGHT(12)) dut12 (
        .clk(clk), .reset(reset),
        .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_x(b_x), .cmd_y(b_y),
        .cmd_data(b_data),
        .resp_valid(b_resp_valid), .resp_ok(b_resp_ok),
        .resp_old(b_resp_old),
        .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_data(b_rd_data),
        .busy(b_busy),
        .red_count(b_red), .blue_count(b_blue)
    );

    int         nvec = 0;
    int         nerr = 0;
    logic [3:0] expq[$];
    logic [2:0] grid [N];
    logic [2:0] rd_at_resp;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cnt(input bit blue);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (!blue && (grid[i] inside {3'd1, 3'd3, 3'd5})) c++;
            if (blue && (grid[i] inside {3'd2, 3'd4, 3'd6})) c++;
        end
        return c;
    endfunction

    task automatic clear_model;
        for (int i = 0; i < N; i++) grid[i] = 3'd0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "/red"}, red_count, cnt(1'b0));
        chk({tag, "/blue"}, blue_count, cnt(1'b1));
    endtask

    task automatic send(input logic [1:0] op, input int x, input int y,
                        input logic [2:0] d, input string tag);
        logic [2:0] old, nw;
        logic       ok;
        logic [3:0] e;
        int         a, lat, n;
        ok  = 1'b0;
        old = 3'd0;
        nw  = 3'd0;
        if (op == 2'd3) begin
            ok = 1'b1;
            clear_model();
        end else if (x < W && y < H) begin
            a   = y * W + x;
            old = grid[a];
            case (op)
                2'd0: begin nw = d; ok = 1'b1; end
                2'd2: begin nw = 3'd0; ok = 1'b1; end
                default: begin
                    nw = d[0] ? 3'd2 : 3'd1;
                    ok = (old <= 3'd2);
                end
            endcase
            if (ok) grid[a] = nw;
        end
        expq.push_back({ok, old});
        lat = (op == 2'd3) ? N : 1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = 4'(x);
        cmd_y     = 4'(y);
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 2000) begin tick(); n++; end
        chk({tag, "/accept"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk({tag, "/ready_low"}, cmd_ready, 0);
        n = 0;
        while (!resp_valid && n < 2 * N) begin tick(); n++; end
        chk({tag, "/latency"}, n, lat);
        rd_at_resp = rd_data;
        e = expq.pop_front();
        chk({tag, "/ok"}, resp_ok, e[3]);
        chk({tag, "/old"}, resp_old, e[2:0]);
        if (op != 2'd3) chk({tag, "/ready_back"}, cmd_ready, 1);
        tick();
        chk({tag, "/pulse"}, resp_valid, 0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_x = 4'(i % W);
            rd_y = 4'(i / W);
            tick();
            chk({tag, "/cell"}, rd_data, grid[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        reset = 1'b1;
        tick();
        tick();
        chk("rst/cmd_ready", cmd_ready, 0);
        chk("rst/busy", busy, 1);
        chk("rst/resp_valid", resp_valid, 0);
        chk("rst/resp_ok", resp_ok, 0);
        chk("rst/resp_old", resp_old, 0);
        chk("rst/red", red_count, 0);
        chk("rst/blue", blue_count, 0);
        chk("rst/rd_data", rd_data, 0);
        reset = 1'b0;

        for (int c = 0; c < N; c++) begin
            rd_x = 4'($urandom_range(0, W - 1));
            rd_y = 4'($urandom_range(0, H - 1));
            chk("sweep/busy", busy, 1);
            chk("sweep/ready", cmd_ready, 0);
            chk("sweep/resp", resp_valid, 0);
            chk("sweep/rd", rd_data, 0);
            tick();
        end
        chk("sweep/done_ready", cmd_ready, 1);
        chk("sweep/done_busy", busy, 0);
        clear_model();
        chk_counts("sweep");
        read_all("sweep");

        send(2'd1, 3, 4, 3'd0, "claim_red");
        chk("claim_red/red", red_count, 1);
        chk_counts("claim_red");
        rd_x = 4'd3; rd_y = 4'd4;
        tick();
        chk("claim_red/rd", rd_data, 1);

        send(2'd1, 3, 4, 3'd1, "claim_blue");
        chk("claim_blue/red", red_count, 0);
        chk("claim_blue/blue", blue_count, 1);

        send(2'd0, 5, 5, 3'd3, "write_player");
        chk("write_player/red", red_count, 1);
        send(2'd1, 5, 5, 3'd1, "claim_blocked");
        chk_counts("claim_blocked");
        rd_x = 4'd5; rd_y = 4'd5;
        tick();
        chk("claim_blocked/rd", rd_data, 3);

        send(2'd2, 3, 4, 3'd0, "erase");
        chk_counts("erase");
        send(2'd0, 0, 0, 3'd7, "write_reserved");
        chk_counts("write_reserved");
        send(2'd1, 0, 0, 3'd0, "claim_reserved");
        send(2'd0, 15, 15, 3'd6, "write_bbomb");
        chk("write_bbomb/blue", blue_count, 1);

        rd_x = 4'd15; rd_y = 4'd15;
        send(2'd0, 15, 15, 3'd5, "overwrite");
        chk("overwrite/rd_old", rd_at_resp, 6);
        chk("overwrite/rd_new", rd_data, 5);
        chk("overwrite/red", red_count, 2);
        chk("overwrite/blue", blue_count, 0);

        for (int i = 0; i < 10; i++)
            send(2'd0, i, 8, 3'((i % 6) + 1), "populate");
        send(2'd1, 1, 8, 3'd1, "claim_over_claim");
        chk_counts("populate");

        send(2'd3, 0, 0, 3'd0, "clear_all");
        chk("clear_all/red", red_count, 0);
        chk("clear_all/blue", blue_count, 0);
        read_all("clear_all");

        send(2'd0, 2, 2, 3'd1, "pre_reset");
        chk("pre_reset/red", red_count, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_x     = 4'd7;
        cmd_y     = 4'd7;
        cmd_data  = 3'd1;
        chk("rst_exec/ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_exec/resp", resp_valid, 0);
        chk("rst_exec/red", red_count, 0);
        chk("rst_exec/blue", blue_count, 0);
        chk("rst_exec/busy", busy, 1);
        n = 0;
        seen = 1'b0;
        while (!cmd_ready && n < 1000) begin
            if (resp_valid) seen = 1'b1;
            tick();
            n++;
        end
        chk("rst_exec/sweep_len", n, N);
        chk("rst_exec/no_resp", seen, 0);
        clear_model();
        read_all("rst_exec");

        b_valid = 1'b1;
        b_op    = 2'd0;
        b_x     = 4'd13;
        b_y     = 4'd2;
        b_data  = 3'd1;
        chk("w12_oor/ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        tick();
        chk("w12_oor/resp", b_resp_valid, 1);
        chk("w12_oor/ok", b_resp_ok, 0);
        chk("w12_oor/old", b_resp_old, 0);
        chk("w12_oor/red", b_red, 0);
        b_rd_x = 4'd1; b_rd_y = 4'd3;
        tick();
        chk("w12_oor/alias_cell", b_rd_data, 0);

        b_valid = 1'b1;
        b_op    = 2'd0;
        b_x     = 4'd0;
        b_y     = 4'd1;
        b_data  = 3'd4;
        tick();
        b_valid = 1'b0;
        tick();
        chk("w12_ok/ok", b_resp_ok, 1);
        chk("w12_ok/blue", b_blue, 1);
        b_rd_x = 4'd0; b_rd_y = 4'd1;
        tick();
        chk("w12_ok/rd", b_rd_data, 4);
        b_rd_x = 4'd12; b_rd_y = 4'd0;
        tick();
        chk("w12_oor/rd", b_rd_data, 0);

        b_valid = 1'b1;
        b_op    = 2'd1;
        b_x     = 4'd3;
        b_y     = 4'd12;
        b_data  = 3'd0;
        tick();
        b_valid = 1'b0;
        tick();
        chk("w12_yoor/resp", b_resp_valid, 1);
        chk("w12_yoor/ok", b_resp_ok, 0);
        chk("w12_yoor/red", b_red, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/momentum_board.md
# momentum_board

Parametrised game-board store for momentumGO. Holds a WIDTH×HEIGHT grid of 3-bit cell codes. Executes write, claim and erase commands through a valid/ready port, with claim-rule checking. Maintains live per-player ownership counts and clears the whole grid with a one-cell-per-cycle sweep after reset or on command. It sits between the game controller, which issues commands, and the renderer/scorer, which uses the read port and the counts.

## Interface
- WIDTH, 16, columns (≥2)
- HEIGHT, 16, rows (≥2)
- X_W, $clog2(WIDTH), column-index width
- Y_W, $clog2(HEIGHT), row-index width
- CNT_W, $clog2(WIDTH*HEIGHT+1), count width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  board accepts command this cycle
- cmd_op  in  2  0 WRITE, 1 CLAIM, 2 ERASE, 3 CLEAR_ALL
- cmd_x  in  X_W  target column
- cmd_y  in  Y_W  target row
- cmd_data  in  3  WRITE: cell code; CLAIM: bit0 = player (0 red, 1 blue)
- resp_valid  out  1  one-cycle completion pulse
- resp_ok  out  1  command applied
- resp_old  out  3  cell code before the command (0 for CLEAR_ALL/rejected-range)
- rd_x  in  X_W  read column
- rd_y  in  Y_W  read row
- rd_data  out  3  cell code at (rd_x, rd_y), 1-cycle latency
- busy  out  1  clear sweep in progress
- red_count  out  CNT_W  cells owned by red (codes 1,3,5)
- blue_count  out  CNT_W  cells owned by blue (codes 2,4,6)

## Operation
- Cell codes: 0 EMPTY, 1 RED_CLAIMED, 2 BLUE_CLAIMED, 3 RED_PLAYER, 4 BLUE_PLAYER, 5 RED_BOMB, 6 BLUE_BOMB, 7 RESERVED (owned by nobody).
- FSM states: CLEAR, IDLE, EXEC. Reset forces CLEAR with sweep index 0.
- CLEAR: writes EMPTY to linear address y*WIDTH+x = idx, one per cycle, idx 0..WIDTH*HEIGHT-1. Then goes to IDLE. The counts are zeroed on entry.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, the command is latched and the target cell is read. CLEAR_ALL goes to CLEAR; all other ops go to EXEC.
- EXEC, for one cycle. If cmd_x≥WIDTH or cmd_y≥HEIGHT, the command is rejected: no write, resp_ok=0, resp_old=0. Otherwise:
  - WRITE: stores cmd_data unconditionally; ok=1.
  - ERASE: stores EMPTY; ok=1.
  - CLAIM(p): if old ∈ {EMPTY, RED_CLAIMED, BLUE_CLAIMED}, stores p's CLAIMED code and ok=1. Otherwise (player, bomb or reserved code) there is no write and ok=0.
- Count update on every applied write: decrement owner(old) and increment owner(new). When the owners match or a count is unaffected, that count is unchanged. Counts never wrap, because total ≤ WIDTH*HEIGHT by construction.
- CLEAR_ALL responds with resp_valid, ok=1, old=0 in the cycle after the final sweep write. The reset-triggered sweep produces no response.
- rd_data reads the array registered. On a same-cycle write to the read address it returns the old value. It reads 0 while busy.
- Reset mid-EXEC or mid-sweep: the pending command is dropped with no response, the counts are zeroed, and the sweep restarts at idx 0.

## Timing
- Reset values: cmd_ready 0, busy 1, resp_valid 0, resp_ok 0, resp_old 0, red_count 0, blue_count 0, rd_data 0.
- Sweep: with reset low from cycle 0, cells are written in cycles 0..WIDTH*HEIGHT-1. busy falls and cmd_ready rises in cycle WIDTH*HEIGHT (256 by default).
- Command accepted in cycle t: EXEC in t+1, cmd_ready=0 in t+1. The array write and count update take effect at the end of t+1. resp_valid, resp_ok and resp_old are valid in t+2, and cmd_ready=1 in t+2. Throughput is one command per 2 cycles.
- A CLEAR_ALL accepted at t makes busy=1 from t+1. It responds at t+1+WIDTH*HEIGHT.
- rd_data reflects (rd_x, rd_y) sampled one cycle earlier. An out-of-range read returns 0.

## Structure
- momentum_pkg: the cell-code constants/enum, the op-code constants, and an owner(code) function returning none/red/blue.
- Sub-module board_ram: WIDTH*HEIGHT×3 array with one write port, a synchronous command-read port and a synchronous display-read port, read-before-write.
- momentum_board holds the FSM, sweep counter, rule check and counters.

## Test plan
- Reset 1 cycle, then release: busy=1 and cmd_ready=0 for 256 cycles, cmd_ready=1 at cycle 256, every rd_data=0, counts 0/0, no resp_valid.
- CLAIM red at (3,4) on EMPTY: resp in t+2 with ok=1, old=0; red_count=1; rd at (3,4) returns 1.
- Then CLAIM blue at (3,4): ok=1, old=1; red_count=0, blue_count=1. WRITE 3 at (5,5) gives red_count=1. A later CLAIM blue at (5,5) gives ok=0, old=3, no change.
- WRITE with cmd_x=16 (needs X_W widened, e.g. a WIDTH=12 instance with x=13): ok=0, old=0, array and counts unchanged.
- Populate 10 cells, then CLEAR_ALL: busy for 256 cycles, resp ok=1 at t+257, counts 0/0, all cells 0.
- Assert reset in the EXEC cycle of a CLAIM: no resp_valid, counts 0, the sweep restarts from idx 0 and finishes 256 cycles after release.
